// File: rtl/phy_strap_sequencer_pkg.sv
// Shared types and default constants for the GMII PHY reset/strap sequencer.
package phy_seq_pkg;

  typedef enum logic [1:0] {
    S_RST,
    S_HOLD,
    S_WAIT,
    S_READY
  } phy_seq_state_t;

  // Strap defaults: MODE = 0001 (GMII), CLK125 enabled, tri-colour LEDs.
  localparam logic [7:0] PHY_STRAP_RXD_GMII = 8'h01;
  localparam logic       PHY_STRAP_RX_DV    = 1'b1;
  localparam logic       PHY_STRAP_CLK125   = 1'b0;

  // Cycle counts for a 125 MHz clk0.
  localparam int PHY_T_RST_CYC   = 1_250_000;  // 10 ms reset low
  localparam int PHY_T_HOLD_CYC  = 125;        // 1 us strap hold
  localparam int PHY_T_READY_CYC = 12_500;     // 100 us PHY wake-up
  localparam int PHY_CNT_W       = 32;

endpackage

// File: rtl/phy_strap_sequencer_if.sv
// Signal bundle between the sequencer, the GPIO request bit and the GMII pads.
interface phy_strap_sequencer_if;

  logic       sw_reset_req;
  logic       phy_rst_n;
  logic       strap_oe;
  logic [7:0] strap_rxd;
  logic       strap_rx_dv;
  logic       strap_clk125;
  logic       mac_reset;
  logic       phy_ready;
  logic       busy;
  logic [7:0] seq_count;

  // Sequencer side.
  modport master (
    input  sw_reset_req,
    output phy_rst_n, strap_oe, strap_rxd, strap_rx_dv, strap_clk125,
    output mac_reset, phy_ready, busy, seq_count
  );

  // GPIO / pad / MAC side.
  modport slave (
    output sw_reset_req,
    input  phy_rst_n, strap_oe, strap_rxd, strap_rx_dv, strap_clk125,
    input  mac_reset, phy_ready, busy, seq_count
  );

endinterface

// File: rtl/phy_strap_sequencer.sv
// Drives PHY reset and strap pins, releases them in order with hold time,
// waits for the PHY to wake up, then releases the MAC. A rising edge on
// sw_reset_req restarts the whole sequence from any state.
module phy_strap_sequencer
  import phy_seq_pkg::*;
#(
  parameter int         T_RST_CYC    = PHY_T_RST_CYC,
  parameter int         T_HOLD_CYC   = PHY_T_HOLD_CYC,
  parameter int         T_READY_CYC  = PHY_T_READY_CYC,
  parameter int         CNT_W        = PHY_CNT_W,
  parameter logic [7:0] STRAP_RXD    = PHY_STRAP_RXD_GMII,
  parameter logic       STRAP_RX_DV  = PHY_STRAP_RX_DV,
  parameter logic       STRAP_CLK125 = PHY_STRAP_CLK125
) (
  input  logic                  clk,
  input  logic                  rst,
  phy_strap_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] LD_RST   = CNT_W'(T_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_READY = CNT_W'(T_READY_CYC - 1);

  phy_seq_state_t   state;
  logic [CNT_W-1:0] tmr;
  logic             req_q;
  logic             req_rise;

  logic             phy_rst_n;
  logic             strap_oe;
  logic             mac_reset;
  logic             phy_ready;
  logic             busy;
  logic [7:0]       seq_count;

  assign req_rise = bus.sw_reset_req & ~req_q;

  // Sequencer FSM: shared down-counter, registered outputs, request override.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RST;
      tmr       <= LD_RST;
      req_q     <= 1'b0;
      phy_rst_n <= 1'b0;
      strap_oe  <= 1'b1;
      mac_reset <= 1'b1;
      phy_ready <= 1'b0;
      busy      <= 1'b1;
      seq_count <= 8'd0;
    end else begin
      // NOTE: non-blocking, so req_rise above still sees last cycle's req_q.
      req_q <= bus.sw_reset_req;
      if (req_rise) begin
        // A fresh request wins over any timer expiry on the same edge.
        state     <= S_RST;
        tmr       <= LD_RST;
        phy_rst_n <= 1'b0;
        strap_oe  <= 1'b1;
        mac_reset <= 1'b1;
        phy_ready <= 1'b0;
        busy      <= 1'b1;
      end else begin
        unique case (state)
          S_RST: begin
            if (tmr == '0) begin
              state     <= S_HOLD;
              tmr       <= LD_HOLD;
              phy_rst_n <= 1'b1;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          S_HOLD: begin
            if (tmr == '0) begin
              state    <= S_WAIT;
              tmr      <= LD_READY;
              strap_oe <= 1'b0;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          S_WAIT: begin
            if (tmr == '0) begin
              state     <= S_READY;
              mac_reset <= 1'b0;
              phy_ready <= 1'b1;
              busy      <= 1'b0;
              if (seq_count != 8'hFF) seq_count <= seq_count + 8'd1;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          S_READY: begin
            // Stays here until a request or reset.
          end
          default: begin
            state <= S_RST;
            tmr   <= LD_RST;
          end
        endcase
      end
    end
  end

  assign bus.phy_rst_n    = phy_rst_n;
  assign bus.strap_oe     = strap_oe;
  assign bus.mac_reset    = mac_reset;
  assign bus.phy_ready    = phy_ready;
  assign bus.busy         = busy;
  assign bus.seq_count    = seq_count;
  assign bus.strap_rxd    = STRAP_RXD;
  assign bus.strap_rx_dv  = STRAP_RX_DV;
  assign bus.strap_clk125 = STRAP_CLK125;

endmodule

// File: tb/tb_phy_strap_sequencer.sv
// Self-checking bench for phy_strap_sequencer with T_RST=8, T_HOLD=2, T_READY=4.
module tb_phy_strap_sequencer;

  localparam int TR   = 8;
  localparam int TH   = 2;
  localparam int TW   = 4;
  localparam int DONE = TR + TH + TW;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edges elapsed since the sequence last started.
  int   m_e;
  logic m_prev;
  int   m_cnt;

  phy_strap_sequencer_if bus ();

  phy_strap_sequencer #(
    .T_RST_CYC   (TR),
    .T_HOLD_CYC  (TH),
    .T_READY_CYC (TW),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic       rst_n;
    logic       oe;
    logic       rdy;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_e    = 0;
    m_prev = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic req);
    int old;
    old = m_e;
    if (req && !m_prev) m_e = 0;
    else if (m_e < DONE) m_e++;
    if (old == DONE - 1 && m_e == DONE && m_cnt < 255) m_cnt++;
    m_prev = req;
  endtask

  task automatic check_all(input string tag);
    logic rdy;
    rdy = (m_e >= DONE);
    check({tag, ".phy_rst_n"}, bus.phy_rst_n, (m_e >= TR));
    check({tag, ".strap_oe"},  bus.strap_oe,  (m_e < TR + TH));
    check({tag, ".phy_ready"}, bus.phy_ready, rdy);
    check({tag, ".mac_reset"}, bus.mac_reset, !rdy);
    check({tag, ".busy"},      bus.busy,      !rdy);
    check({tag, ".seq_count"}, bus.seq_count, m_cnt);
    if (bus.strap_oe) begin
      check({tag, ".strap_rxd"},    bus.strap_rxd,    8'h01);
      check({tag, ".strap_rx_dv"},  bus.strap_rx_dv,  1'b1);
      check({tag, ".strap_clk125"}, bus.strap_clk125, 1'b0);
    end
  endtask

  // One clock edge with req presented; optionally compare all outputs after.
  task automatic tick(input logic req, input bit chk);
    bus.sw_reset_req = req;
    @(posedge clk);
    model_step(req);
    #1;
    if (chk) check_all("seq");
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs checked before any edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.sw_reset_req = 1'b0;
    model_reset();

    // Power-up table: edges 1..16, then a request pulse at 17 held at 18.
    for (int i = 0; i < 7; i++) vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0};  // edge 8: reset released
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0};  // edge 9
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0};  // edge 10: straps tri-stated
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0};  // edge 13
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd1};  // edge 14: ready
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1};  // edge 17: request restarts
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1};  // edge 18: held, no retrigger

    #3 check_all("reset_hold");
    #24 rst = 1'b0;
    #1 check_all("after_release");

    for (int i = 0; i < 18; i++) begin
      tick(vecs[i].req, 1'b0);
      check($sformatf("tbl%0d.phy_rst_n", i + 1), bus.phy_rst_n, vecs[i].rst_n);
      check($sformatf("tbl%0d.strap_oe", i + 1),  bus.strap_oe,  vecs[i].oe);
      check($sformatf("tbl%0d.phy_ready", i + 1), bus.phy_ready, vecs[i].rdy);
      check($sformatf("tbl%0d.mac_reset", i + 1), bus.mac_reset, !vecs[i].rdy);
      check($sformatf("tbl%0d.seq_count", i + 1), bus.seq_count, vecs[i].cnt);
      check_all($sformatf("tbl%0d", i + 1));
    end

    // Release request and let the restarted sequence finish.
    repeat (DONE - 1) tick(1'b0, 1'b1);
    check("restart_done.ready", bus.phy_ready, 1'b1);
    check("restart_done.count", bus.seq_count, 8'd2);

    // Restart, then async reset while in HOLD: count must clear immediately.
    tick(1'b1, 1'b1);
    repeat (TR + 1) tick(1'b0, 1'b1);
    async_reset();
    check("async_hold.count", bus.seq_count, 8'd0);
    check("async_hold.rst_n", bus.phy_rst_n, 1'b0);

    // Fresh power-up, request at edge 12 (mid-WAIT).
    repeat (11) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check("midwait.strap_oe", bus.strap_oe, 1'b1);
    check("midwait.rst_n", bus.phy_rst_n, 1'b0);
    repeat (13) tick(1'b0, 1'b1);
    check("midwait.not_ready_25", bus.phy_ready, 1'b0);
    tick(1'b0, 1'b1);
    check("midwait.ready_26", bus.phy_ready, 1'b1);
    check("midwait.count", bus.seq_count, 8'd1);

    // Held request from edge 8: one restart overriding the RST expiry.
    async_reset();
    repeat (TR - 1) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check("held.restart_rst_n", bus.phy_rst_n, 1'b0);
    repeat (40) tick(1'b1, 1'b1);
    check("held.ready", bus.phy_ready, 1'b1);
    check("held.count", bus.seq_count, 8'd1);
    tick(1'b0, 1'b1);

    // Randomised requests and occasional async resets against the model.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 11) == 0) ? 1'b1 : bus.sw_reset_req & ($urandom_range(0, 1) == 1), 1'b1);
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    // Saturation: 300 complete sequences.
    tick(1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0);
      repeat (DONE) tick(1'b0, 1'b0);
      check($sformatf("sat%0d.count", i), bus.seq_count, m_cnt);
    end
    check("sat.final", bus.seq_count, 8'd255);
    check_all("sat_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phy_strap_sequencer.md
# phy_strap_sequencer

Sequences the reset and power-up strapping of the external GMII Ethernet PHY. It drives the PHY's strap pins (shared with RXD/RX_DV/CLK125) during reset. It releases reset with the required strap hold time, then tri-states the straps, waits for the PHY to become ready, and only then releases the MAC. Software can re-run the full sequence through a GPIO bit. The block sits in the top-level `clk0` domain, between the GPIO bus and the GMII pad tristates.

## Interface
Parameters:
- `T_RST_CYC`, 1250000: PHY reset low time in clk cycles (10 ms at 125 MHz); must be ≥ 1.
- `T_HOLD_CYC`, 125: strap hold after reset release (1 µs); must be ≥ 1.
- `T_READY_CYC`, 12500: wait after strap release before PHY is usable (100 µs); must be ≥ 1.
- `CNT_W`, 32: timer width; must hold the largest T_*_CYC − 1.
- `STRAP_RXD`, 8'h01: value on RXD[7:0] while strapping (MODE = 0001, GMII).
- `STRAP_RX_DV`, 1'b1: RX_DV strap (CLK125_EN = 1).
- `STRAP_CLK125`, 1'b0: CLK125 pin strap (LED_MODE = tri-colour).

Ports:
- `clk` in 1: system clock (`clk0`, 125 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `sw_reset_req` in 1: software re-sequence request, synchronous to `clk`, rising-edge sensitive.
- `phy_rst_n` out 1: PHY hardware reset, active-low.
- `strap_oe` out 1: 1 = pads drive strap values, 0 = pads tri-stated (inputs).
- `strap_rxd` out 8: strap value for RXD pads; constant `STRAP_RXD`.
- `strap_rx_dv` out 1: constant `STRAP_RX_DV`.
- `strap_clk125` out 1: constant `STRAP_CLK125`.
- `mac_reset` out 1: active-high reset to the MAC/TSE; held until the PHY is ready.
- `phy_ready` out 1: 1 once the sequence has completed.
- `busy` out 1: 1 in every state other than READY.
- `seq_count` out 8: number of completed sequences, saturating at 255.

## Operation
- The FSM has four states: RST, HOLD, WAIT and READY. A single down-counter `tmr` is loaded with T_x_CYC − 1 on entry to each timed state. The state advances on the edge where `tmr == 0`, so each timed state lasts exactly T_x_CYC cycles.
- RST: `phy_rst_n=0`, `strap_oe=1`, `mac_reset=1`. Advances to HOLD.
- HOLD: `phy_rst_n=1`, `strap_oe=1`. Advances to WAIT.
- WAIT: `phy_rst_n=1`, `strap_oe=0`. Advances to READY.
- READY: `phy_rst_n=1`, `strap_oe=0`, `mac_reset=0`, `phy_ready=1`, `busy=0`. On entry, `seq_count` increments unless it is already 255. READY persists indefinitely.
- Request detection:
  - `req_q` holds the previous value of `sw_reset_req`.
  - A rising edge is `sw_reset_req & ~req_q`.
  - A rising edge in any state, including mid-sequence, forces RST and reloads `tmr` with T_RST_CYC − 1. The sequence restarts from the beginning; no request is queued.
  - A level held high does not retrigger.
- Simultaneous events: a rising edge on the same edge that `tmr` reaches 0 takes priority, so the FSM goes to RST.
- `mac_reset` is 1 in RST, HOLD and WAIT.
- Reset values under `rst`: state RST, `tmr = T_RST_CYC−1`, `req_q = 0`, `phy_rst_n=0`, `strap_oe=1`, `mac_reset=1`, `phy_ready=0`, `busy=1`, `seq_count=0`.
- Asserting `rst` mid-sequence immediately (asynchronously) re-enters RST; `seq_count` is cleared.

## Timing
- All control outputs are registered; there are no combinational paths from input to output. The strap value outputs are constants.
- Edge numbering: edge 1 is the first rising edge after `rst` deasserts. Then:
  - `phy_rst_n` rises after edge T_RST_CYC.
  - `strap_oe` falls after edge T_RST_CYC+T_HOLD_CYC.
  - `phy_ready` rises and `mac_reset` falls after edge T_RST_CYC+T_HOLD_CYC+T_READY_CYC.
- Request latency: `sw_reset_req` is sampled high at edge k and was low at edge k−1. After edge k, `phy_rst_n=0`, `strap_oe=1`, `phy_ready=0` and `mac_reset=1`.
- Strap overlap: `strap_oe` rises on the same edge that `phy_rst_n` falls and falls T_HOLD_CYC cycles after `phy_rst_n` rises. Straps are therefore never tri-stated while `phy_rst_n` is low.

## Structure
- Package `phy_seq_pkg` holds:
  - the enum `phy_seq_state_t {S_RST, S_HOLD, S_WAIT, S_READY}`;
  - default strap constants `PHY_STRAP_RXD_GMII = 8'h01`, `PHY_STRAP_RX_DV = 1'b1`, `PHY_STRAP_CLK125 = 1'b0`;
  - the cycle constants for 125 MHz.
- Single module. No sub-module: the timer is one down-counter shared by the states.
- Pad tristating (`assign pad = strap_oe ? strap : 'z`) stays at top level.

## Test plan
All scenarios use T_RST_CYC=8, T_HOLD_CYC=2, T_READY_CYC=4.
- Power-up: release `rst` → `phy_rst_n` 0 for edges 1–8 and 1 after edge 8; `strap_oe` 0 after edge 10; `phy_ready`=1, `mac_reset`=0, `seq_count`=1 after edge 14; `strap_rxd`=8'h01 whenever `strap_oe`=1.
- Software request in READY: pulse `sw_reset_req` at edge 20 → RST after edge 20; `phy_ready` returns after edge 34; `seq_count`=2.
- Request mid-WAIT: pulse at edge 12 → RST after edge 12, `strap_oe`=1 again; `phy_ready` rises after edge 26; `seq_count`=1.
- Held request and simultaneous event: hold `sw_reset_req` high from edge 8 onward → exactly one restart (`tmr` expiry at edge 8 overridden); no further restarts while held.
- Async reset mid-HOLD: assert `rst` between edges 9 and 10 → outputs immediately at reset values with `seq_count`=0; the sequence restarts on release.
- Saturation: issue 300 requests, each allowed to complete → `seq_count` stays at 255.
